apb_i2c_regs: RTL and testbench
===============================

// Module: apb_i2c_regs
// PURPOSE
//  APB3 slave register front-end feeding i2c_controller: holds slave address/rw/repeated-start config,
//  buffers TX bytes in a small FIFO, and issues the single-cycle enable pulse that launches a transfer.
//  Sits between the APB bus and i2c_controller; tracks the transfer to completion and exposes status.
// PARAMETERS
//  FIFO_DEPTH  4   TX FIFO entries (power of 2, >=2)
//  FIFO_AW     2   log2(FIFO_DEPTH)
//  START_TMO   16  cycles to wait for i2c_busy to rise after enable before flagging error
// PORTS
//  clk                  in   1  system clock, all logic rising-edge
//  rst                  in   1  synchronous, active-high reset
//  psel,penable,pwrite  in   1  APB3 control
//  paddr                in   4  byte address, [1:0] ignored
//  pwdata               in   32 write data
//  prdata               out  32 read data
//  pready               out  1  tied 1 (zero wait states)
//  pslverr              out  1  error on access phase
//  enable               out  1  launch pulse to i2c_controller
//  slave_address        out  7  config to controller
//  rw                   out  1  1=read, 0=write
//  repeated_start_cond  out  1  config to controller
//  data_in              out  8  TX FIFO head (0 when empty)
//  i2c_busy             in   1  controller transfer in progress
//  i2c_data_ack         in   1  1-cycle pulse: controller consumed data_in -> pop
//  irq                  out  1  level: DONE & IE
// BEHAVIOUR
//  Registers (access completes when psel&penable; write effect next edge):
//   0x0 CTRL  [0]START(W1, reads 0) [1]RW [2]RSTART [3]IE [4]FLUSH(W1, reads 0)
//   0x4 ADDR  [6:0] slave_address
//   0x8 TXDATA W: push pwdata[7:0]; R: 0
//   0xC STATUS [0]BUSY [1]FULL [2]EMPTY [3]DONE(W1C) [4]ERR(W1C) [10:8]COUNT
//  pslverr=1 (no state change) when: TXDATA write with FIFO full; CTRL write with START=1 while
//   FSM!=IDLE; FLUSH while FSM!=IDLE; paddr[3:2] valid but unused bits never error.
//  Reset: all regs 0, FIFO empty, FSM IDLE, enable=0, prdata=0, pslverr=0, irq=0.
//  FSM: IDLE -START write-> LAUNCH: enable=1 exactly one cycle -> WAIT_BUSY.
//   WAIT_BUSY: i2c_busy=1 -> ACTIVE; START_TMO cycles elapsed -> set ERR, -> IDLE.
//   ACTIVE: i2c_busy falls -> set DONE, -> IDLE.
//  slave_address/rw/repeated_start_cond are snapshot at START; CTRL/ADDR writes during transfer
//   update registers only, outputs unchanged until next START.
//  FIFO: count width FIFO_AW+1, pointers wrap modulo FIFO_DEPTH. Simultaneous push+pop when full:
//   pop succeeds, push succeeds (count unchanged). Pop when empty ignored, sets ERR.
//  Push when full rejected (pslverr). Write-only START with empty FIFO and rw=0 is allowed.
//  W1C of DONE on same cycle as hardware set: set wins.
//  Reset mid-transfer: FSM to IDLE, enable=0 immediately on next edge, FIFO cleared.
//  prdata registered: valid in access phase (captured on setup phase address).
// STRUCTURE
//  Package i2c_apb_pkg: register offsets, CTRL/STATUS bit indices, FSM state encoding (2-bit).
//  One sub-module: i2c_tx_fifo (sync FIFO, push/pop/flush, full/empty/count); rest in top.
// TESTING
//  1. Reset then read STATUS -> 0x0000_0004 (EMPTY only); enable=0 throughout.
//  2. Write ADDR=0x6B, CTRL=0x3 (START,RW) -> enable high 1 cycle, slave_address=7'h6B, rw=1.
//  3. Push 0xAA,0x55,0x01,0x02, 5th push -> pslverr=1, COUNT=4, FULL=1; data_in=0xAA;
//     two i2c_data_ack pulses -> data_in=0x01, COUNT=2.
//  4. START, hold i2c_busy=0 for 16 cycles -> ERR=1, FSM IDLE; W1C 0x10 -> ERR=0.
//  5. START, i2c_busy high 20 cycles then low -> DONE=1, irq=1 if IE; 2nd START mid-transfer -> pslverr.
//  6. Assert rst during ACTIVE with FIFO COUNT=3 -> next cycle STATUS=0x4, enable=0.

Source files
------------

// File: rtl/i2c_apb_pkg.sv
// Shared definitions for the APB register front-end of the I2C controller:
// word offsets, CTRL/STATUS bit positions and the transfer FSM encoding.
package i2c_apb_pkg;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_ADDR   = 2'd1;
  localparam logic [1:0] OFS_TXDATA = 2'd2;
  localparam logic [1:0] OFS_STATUS = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_RW     = 1;
  localparam int CTRL_RSTART = 2;
  localparam int CTRL_IE     = 3;
  localparam int CTRL_FLUSH  = 4;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_DONE      = 3;
  localparam int ST_ERR       = 4;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_ACTIVE    = 2'd3
  } i2c_state_e;

endpackage

// File: rtl/i2c_tx_fifo.sv
// Byte-wide synchronous TX FIFO. A pop on a full FIFO frees a slot for a
// same-cycle push; pops on an empty FIFO are dropped.
module i2c_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/apb_i2c_regs.sv
// APB3 register front-end for i2c_controller: config, TX FIFO, launch pulse
// and transfer tracking with DONE/ERR status.
//   state       | meaning
//   S_IDLE      | no transfer, START accepted
//   S_LAUNCH    | enable pulse to controller (one cycle)
//   S_WAIT_BUSY | waiting for i2c_busy, timeout counter running
//   S_ACTIVE    | transfer running, waiting for i2c_busy to fall
module apb_i2c_regs
  import i2c_apb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2,
  parameter int START_TMO  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        enable,
  output logic [6:0]  slave_address,
  output logic        rw,
  output logic        repeated_start_cond,
  output logic [7:0]  data_in,
  input  logic        i2c_busy,
  input  logic        i2c_data_ack,
  output logic        irq
);

  localparam int TMO_W = $clog2(START_TMO + 1);

  i2c_state_e       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ctrl_rw_q, ctrl_rw_d, ctrl_rstart_q, ctrl_rstart_d, ctrl_ie_q, ctrl_ie_d;
  logic [6:0]       addr_q, addr_d;
  logic             done_q, done_d, err_q, err_d;
  logic [6:0]       out_addr_q, out_addr_d;
  logic             out_rw_q, out_rw_d, out_rstart_q, out_rstart_d;
  logic [31:0]      prdata_q, prdata_d, rd_mux;

  logic [1:0]         idx;
  logic               wr_acc, wr_err, wr_ok, busy;
  logic               ctrl_wr, addr_wr, push, status_wr, start, flush;
  logic               tmo_err, done_set;
  logic               fifo_full, fifo_empty;
  logic [FIFO_AW:0]   fifo_count;
  logic               unused_ok;

  assign idx    = paddr[3:2];
  assign busy   = (state_q != S_IDLE);
  assign wr_acc = psel & penable & pwrite;

  // A full FIFO still takes a push if the controller pops in the same cycle.
  assign wr_err = ((idx == OFS_TXDATA) & fifo_full & ~i2c_data_ack)
                | ((idx == OFS_CTRL) & busy & (pwdata[CTRL_START] | pwdata[CTRL_FLUSH]));
  assign wr_ok     = wr_acc & ~wr_err;
  assign ctrl_wr   = wr_ok & (idx == OFS_CTRL);
  assign addr_wr   = wr_ok & (idx == OFS_ADDR);
  assign push      = wr_ok & (idx == OFS_TXDATA);
  assign status_wr = wr_ok & (idx == OFS_STATUS);
  assign start     = ctrl_wr & pwdata[CTRL_START];
  assign flush     = ctrl_wr & pwdata[CTRL_FLUSH];

  assign pready              = 1'b1;
  assign pslverr             = wr_acc & wr_err;
  assign prdata              = prdata_q;
  assign enable              = (state_q == S_LAUNCH);
  assign slave_address       = out_addr_q;
  assign rw                  = out_rw_q;
  assign repeated_start_cond = out_rstart_q;
  assign irq                 = done_q & ctrl_ie_q;
  assign unused_ok           = ^{pwdata[31:8], pwdata[5], paddr[1:0]};

  i2c_tx_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (i2c_data_ack),
    .flush (flush),
    .wdata (pwdata[7:0]),
    .rdata (data_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    tmo_err  = 1'b0;
    done_set = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LAUNCH;
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
        tmo_d   = TMO_W'(START_TMO - 1);
      end
      S_WAIT_BUSY: begin
        if (i2c_busy) begin
          state_d = S_ACTIVE;
        end else if (tmo_q == '0) begin
          state_d = S_IDLE;
          tmo_err = 1'b1;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      S_ACTIVE: begin
        if (!i2c_busy) begin
          state_d  = S_IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_rw_d     = ctrl_rw_q;
    ctrl_rstart_d = ctrl_rstart_q;
    ctrl_ie_d     = ctrl_ie_q;
    addr_d        = addr_q;
    out_addr_d    = out_addr_q;
    out_rw_d      = out_rw_q;
    out_rstart_d  = out_rstart_q;
    if (ctrl_wr) begin
      ctrl_rw_d     = pwdata[CTRL_RW];
      ctrl_rstart_d = pwdata[CTRL_RSTART];
      ctrl_ie_d     = pwdata[CTRL_IE];
    end
    if (addr_wr) addr_d = pwdata[6:0];
    // Controller-facing config is frozen at launch; RW/RSTART come from the START write itself.
    if (start) begin
      out_addr_d   = addr_q;
      out_rw_d     = pwdata[CTRL_RW];
      out_rstart_d = pwdata[CTRL_RSTART];
    end
    done_d = (done_q & ~(status_wr & pwdata[ST_DONE])) | done_set;
    err_d  = (err_q & ~(status_wr & pwdata[ST_ERR])) | tmo_err | (i2c_data_ack & fifo_empty);
  end

  always_comb begin
    rd_mux = '0;
    case (idx)
      OFS_CTRL: begin
        rd_mux[CTRL_RW]     = ctrl_rw_q;
        rd_mux[CTRL_RSTART] = ctrl_rstart_q;
        rd_mux[CTRL_IE]     = ctrl_ie_q;
      end
      OFS_ADDR: rd_mux[6:0] = addr_q;
      OFS_STATUS: begin
        rd_mux[ST_BUSY]                        = busy;
        rd_mux[ST_FULL]                        = fifo_full;
        rd_mux[ST_EMPTY]                       = fifo_empty;
        rd_mux[ST_DONE]                        = done_q;
        rd_mux[ST_ERR]                         = err_q;
        rd_mux[ST_COUNT_LSB +: FIFO_AW + 1]    = fifo_count;
      end
      default: rd_mux = '0;
    endcase
    prdata_d = (psel & ~penable & ~pwrite) ? rd_mux : prdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tmo_q         <= '0;
      ctrl_rw_q     <= 1'b0;
      ctrl_rstart_q <= 1'b0;
      ctrl_ie_q     <= 1'b0;
      addr_q        <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      out_addr_q    <= '0;
      out_rw_q      <= 1'b0;
      out_rstart_q  <= 1'b0;
      prdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      ctrl_rw_q     <= ctrl_rw_d;
      ctrl_rstart_q <= ctrl_rstart_d;
      ctrl_ie_q     <= ctrl_ie_d;
      addr_q        <= addr_d;
      done_q        <= done_d;
      err_q         <= err_d;
      out_addr_q    <= out_addr_d;
      out_rw_q      <= out_rw_d;
      out_rstart_q  <= out_rstart_d;
      prdata_q      <= prdata_d;
    end
  end

endmodule

// File: tb/tb_apb_i2c_regs.sv
// Directed bench for apb_i2c_regs: APB register access, TX FIFO, launch pulse,
// start timeout, transfer completion and reset during a transfer.
module tb_apb_i2c_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        enable;
  logic [6:0]  slave_address;
  logic        rw, repeated_start_cond;
  logic [7:0]  data_in;
  logic        i2c_busy, i2c_data_ack;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] A_CTRL = 4'h0, A_ADDR = 4'h4, A_TX = 4'h8, A_STAT = 4'hC;

  apb_i2c_regs dut (
    .clk                 (clk),
    .rst                 (rst),
    .psel                (psel),
    .penable             (penable),
    .pwrite              (pwrite),
    .paddr               (paddr),
    .pwdata              (pwdata),
    .prdata              (prdata),
    .pready              (pready),
    .pslverr             (pslverr),
    .enable              (enable),
    .slave_address       (slave_address),
    .rw                  (rw),
    .repeated_start_cond (repeated_start_cond),
    .data_in             (data_in),
    .i2c_busy            (i2c_busy),
    .i2c_data_ack        (i2c_data_ack),
    .irq                 (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_wr(input logic [3:0] a, input logic [31:0] d, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    #1 err = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [3:0] a, input logic [31:0] d,
                        input logic exp_err);
    logic e;
    apb_wr(a, d, e);
    chk(tag, {31'd0, e}, {31'd0, exp_err});
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    apb_rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    i2c_data_ack = 1'b1;
    @(negedge clk);
    i2c_data_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; i2c_busy = 1'b0; i2c_data_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_enable", {31'd0, enable}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    rst = 1'b0;

    // reset state
    rd_chk("t1_status", A_STAT, 32'h0000_0004);
    chk("t1_enable", {31'd0, enable}, 32'd0);
    chk("t1_irq", {31'd0, irq}, 32'd0);

    // launch with RW=1, then let it time out
    wr_chk("t2_addr_wr", A_ADDR, 32'h6B, 1'b0);
    wr_chk("t2_ctrl_wr", A_CTRL, 32'h3, 1'b0);
    chk("t2_enable_hi", {31'd0, enable}, 32'd1);
    chk("t2_slave_addr", {25'd0, slave_address}, 32'h6B);
    chk("t2_rw", {31'd0, rw}, 32'd1);
    chk("t2_rsc", {31'd0, repeated_start_cond}, 32'd0);
    @(negedge clk);
    chk("t2_enable_lo", {31'd0, enable}, 32'd0);
    rd_chk("t2_ctrl_rd", A_CTRL, 32'h2);
    rd_chk("t2_addr_rd", A_ADDR, 32'h6B);
    repeat (20) @(negedge clk);
    rd_chk("t2_status_err", A_STAT, 32'h14);
    wr_chk("t2_w1c_err", A_STAT, 32'h10, 1'b0);
    rd_chk("t2_status_clr", A_STAT, 32'h4);

    // TX FIFO fill, overflow, pops
    wr_chk("t3_push0", A_TX, 32'hAA, 1'b0);
    wr_chk("t3_push1", A_TX, 32'h55, 1'b0);
    wr_chk("t3_push2", A_TX, 32'h01, 1'b0);
    wr_chk("t3_push3", A_TX, 32'h02, 1'b0);
    wr_chk("t3_push_full", A_TX, 32'h77, 1'b1);
    rd_chk("t3_status_full", A_STAT, 32'h0000_0402);
    chk("t3_head", {24'd0, data_in}, 32'hAA);
    ack_pulse();
    ack_pulse();
    chk("t3_head_after2", {24'd0, data_in}, 32'h01);
    rd_chk("t3_status_cnt2", A_STAT, 32'h0000_0200);
    ack_pulse();
    chk("t3_head_after3", {24'd0, data_in}, 32'h02);
    wr_chk("t3_flush", A_CTRL, 32'h10, 1'b0);
    rd_chk("t3_status_flushed", A_STAT, 32'h4);
    chk("t3_head_empty", {24'd0, data_in}, 32'h00);
    ack_pulse();
    rd_chk("t3_pop_empty_err", A_STAT, 32'h14);
    wr_chk("t3_w1c_err", A_STAT, 32'h10, 1'b0);

    // start timeout boundary: still busy one cycle before the limit
    wr_chk("t4_start", A_CTRL, 32'h1, 1'b0);
    chk("t4_enable_hi", {31'd0, enable}, 32'd1);
    chk("t4_rw", {31'd0, rw}, 32'd0);
    repeat (15) @(negedge clk);
    rd_chk("t4_busy_pre_tmo", A_STAT, 32'h5);
    rd_chk("t4_err_tmo", A_STAT, 32'h14);
    wr_chk("t4_w1c_err", A_STAT, 32'h10, 1'b0);
    rd_chk("t4_status_clr", A_STAT, 32'h4);

    // full transfer with IE, rejected writes mid-transfer
    wr_chk("t5_start", A_CTRL, 32'h9, 1'b0);
    chk("t5_enable_hi", {31'd0, enable}, 32'd1);
    @(negedge clk);
    i2c_busy = 1'b1;
    wr_chk("t5_start_busy", A_CTRL, 32'h9, 1'b1);
    wr_chk("t5_addr_busy", A_ADDR, 32'h12, 1'b0);
    chk("t5_snapshot", {25'd0, slave_address}, 32'h6B);
    wr_chk("t5_flush_busy", A_CTRL, 32'h18, 1'b1);
    rd_chk("t5_status_active", A_STAT, 32'h5);
    repeat (8) @(negedge clk);
    i2c_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_irq", {31'd0, irq}, 32'd1);
    rd_chk("t5_status_done", A_STAT, 32'hC);
    wr_chk("t5_w1c_done", A_STAT, 32'h8, 1'b0);
    rd_chk("t5_status_clr", A_STAT, 32'h4);
    chk("t5_irq_clr", {31'd0, irq}, 32'd0);

    // reset during an active transfer with 3 bytes queued
    wr_chk("t6_push0", A_TX, 32'h11, 1'b0);
    wr_chk("t6_push1", A_TX, 32'h22, 1'b0);
    wr_chk("t6_push2", A_TX, 32'h33, 1'b0);
    wr_chk("t6_start", A_CTRL, 32'h1, 1'b0);
    chk("t6_new_addr", {25'd0, slave_address}, 32'h12);
    @(negedge clk);
    i2c_busy = 1'b1;
    repeat (3) @(negedge clk);
    rd_chk("t6_status_active", A_STAT, 32'h0000_0301);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_enable_rst", {31'd0, enable}, 32'd0);
    chk("t6_data_in_rst", {24'd0, data_in}, 32'd0);
    chk("t6_addr_rst", {25'd0, slave_address}, 32'd0);
    rst = 1'b0;
    i2c_busy = 1'b0;
    rd_chk("t6_status_rst", A_STAT, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
